// File: rtl/four_way_mux_arbiter_if.sv
// ----------------------------------------------------------------------------
// four_way_mux_arbiter_if
// Bundles the request/data inputs and the grant/data outputs of the four-way
// mux arbiter.
//   req       [3:0]        one request bit per requester (index 0..3)
//   in0..in3  [WIDTH-1:0]  requester data
//   grant     [3:0]        registered one-hot grant, or all-zero
//   op        [1:0]        registered index of the granted requester
//   out       [WIDTH-1:0]  registered data of the granted requester
//   out_valid              out holds data captured during an ownership cycle
//   busy                   arbiter is in its OWNED state
// Modports:
//   master : the requester side (drives req/in*, observes the results)
//   slave  : the arbiter side
// ----------------------------------------------------------------------------
interface four_way_mux_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       req;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [3:0]       grant;
    logic [1:0]       op;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    modport master (
        output req, in0, in1, in2, in3,
        input  grant, op, out, out_valid, busy
    );

    modport slave (
        input  req, in0, in1, in2, in3,
        output grant, op, out, out_valid, busy
    );
endinterface

// File: rtl/four_way_mux_arbiter.sv
// ----------------------------------------------------------------------------
// four_way_mux_arbiter
// Round-robin arbiter for four requesters with a bounded ownership length.
// A requester, once granted, owns the mux until it drops its request or has
// held the grant for HOLD_MAX cycles; every release is followed by at least
// one IDLE cycle. While owned, the granted requester's data is registered
// onto out each cycle.
// Ports:
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high reset
//   bus    : four_way_mux_arbiter_if.slave (req, in0..in3 -> grant, op, out,
//            out_valid, busy)
// Parameters:
//   WIDTH    : data width of in0..in3 and out (must match the interface)
//   HOLD_MAX : maximum consecutive grant cycles per ownership, 1..255
// ----------------------------------------------------------------------------
module four_way_mux_arbiter #(
    parameter int WIDTH    = 16,
    parameter int HOLD_MAX = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    four_way_mux_arbiter_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // Hold counter is 8 bits wide: HOLD_MAX never exceeds 255.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);

    state_t           r_state;
    logic [3:0]       r_grant;
    logic [1:0]       r_op;
    logic [1:0]       r_ptr;
    logic [7:0]       r_hold_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       w_op_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [7:0]       w_hold_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_out_valid_nxt;
    logic             w_busy_nxt;
    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_owner_data;

    // First set request bit searching upward (mod 4) starting just after ptr,
    // so the previous owner is the lowest priority.
    function automatic logic [1:0] pick_next(input logic [3:0] req,
                                             input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Data of the current owner, selected by the registered op.
    always_comb begin
        w_owner_data = bus.in0;
        case (r_op)
            2'd0:    w_owner_data = bus.in0;
            2'd1:    w_owner_data = bus.in1;
            2'd2:    w_owner_data = bus.in2;
            2'd3:    w_owner_data = bus.in3;
            default: w_owner_data = bus.in0;
        endcase
    end

    // Next-state and next-output logic of the IDLE/OWNED controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_op_nxt        = r_op;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_sel           = pick_next(bus.req, r_ptr);

        case (r_state)
            ST_IDLE: begin
                if (bus.req != 4'b0000) begin
                    w_state_nxt = ST_OWNED;
                    w_grant_nxt = onehot4(w_sel);
                    w_op_nxt    = w_sel;
                    w_ptr_nxt   = w_sel;
                    w_hold_nxt  = 8'd0;
                end else begin
                    w_grant_nxt = 4'b0000;
                end
            end
            ST_OWNED: begin
                // out follows the owner on every owned edge, including the
                // releasing one; out_valid marks the cycle after it.
                w_out_nxt       = w_owner_data;
                w_out_valid_nxt = 1'b1;
                if (r_hold_cnt >= HOLD_SAT) begin
                    w_hold_nxt = HOLD_SAT;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
                // Only the owner's own request bit matters here; a drop and
                // the hold limit coinciding is just one release.
                if (!bus.req[r_op] || (r_hold_cnt == HOLD_LAST)) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 4'b0000;
                end else begin
                    w_grant_nxt = onehot4(r_op);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_OWNED);
    end

    // State and output registers; reset forces requester 0 to top priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= 4'b0000;
            r_op        <= 2'd0;
            r_ptr       <= 2'd3;
            r_hold_cnt  <= 8'd0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_op        <= w_op_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.op        = r_op;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_four_way_mux_arbiter.sv
// ----------------------------------------------------------------------------
// tb_four_way_mux_arbiter
// Directed bench for four_way_mux_arbiter: a HOLD_MAX=8 instance carries the
// main scenarios, a HOLD_MAX=1 instance checks single-cycle ownership.
// Inputs change at the falling edge, outputs are checked at the falling edge.
// ----------------------------------------------------------------------------
module tb_four_way_mux_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    four_way_mux_arbiter_if #(.WIDTH(16)) bus  ();
    four_way_mux_arbiter_if #(.WIDTH(16)) bus1 ();

    four_way_mux_arbiter #(.WIDTH(16), .HOLD_MAX(8)) u_dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    four_way_mux_arbiter #(.WIDTH(16), .HOLD_MAX(1)) u_dut1 (
        .clock (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then park on the falling edge for checks/drive.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] rot_in [4];
        int          owners [5];
        logic [3:0]  exp_g;
        logic [15:0] v;

        n_cmp = 0;
        n_err = 0;
        rot_in = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        owners = '{0, 1, 2, 3, 0};

        // ---- reset held 2 cycles with all requests high ----
        reset    = 1'b1;
        bus.req  = 4'b1111;
        bus.in0  = rot_in[0];
        bus.in1  = rot_in[1];
        bus.in2  = rot_in[2];
        bus.in3  = rot_in[3];
        bus1.req = 4'b0000;
        bus1.in0 = 16'hA0A0;
        bus1.in1 = 16'hA1A1;
        bus1.in2 = 16'hA2A2;
        bus1.in3 = 16'hA3A3;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_grant", 32'(bus.grant), 32'h0);
            chk("rst_out", 32'(bus.out), 32'h0);
            chk("rst_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_busy", 32'(bus.busy), 32'h0);
        end

        // ---- steady req=1111: owners 0,1,2,3,0, 8 cycles each, 1 idle gap ----
        reset = 1'b0;
        tick();
        for (int o = 0; o < 5; o++) begin
            exp_g = 4'b0001 << owners[o];
            for (int k = 0; k < 8; k++) begin
                chk("rot_grant", 32'(bus.grant), 32'(exp_g));
                chk("rot_op", 32'(bus.op), 32'(owners[o]));
                chk("rot_busy", 32'(bus.busy), 32'h1);
                chk("rot_valid", 32'(bus.out_valid), (k == 0) ? 32'h0 : 32'h1);
                if (k > 0) chk("rot_out", 32'(bus.out), 32'(rot_in[owners[o]]));
                tick();
            end
            chk("rot_gap_grant", 32'(bus.grant), 32'h0);
            chk("rot_gap_busy", 32'(bus.busy), 32'h0);
            chk("rot_gap_valid", 32'(bus.out_valid), 32'h1);
            chk("rot_gap_out", 32'(bus.out), 32'(rot_in[owners[o]]));
            if (o < 4) tick();
        end
        bus.req = 4'b0000;
        tick();
        chk("idle_grant", 32'(bus.grant), 32'h0);
        chk("idle_valid", 32'(bus.out_valid), 32'h0);
        chk("idle_out_hold", 32'(bus.out), 32'h1111);

        // ---- req=0100 held 3 cycles, in = 0/1/2/3 ----
        bus.in0 = 16'h0000;
        bus.in1 = 16'h0001;
        bus.in2 = 16'h0002;
        bus.in3 = 16'h0003;
        bus.req = 4'b0100;
        tick();
        chk("r2_grant_c1", 32'(bus.grant), 32'h4);
        chk("r2_op_c1", 32'(bus.op), 32'h2);
        chk("r2_valid_c1", 32'(bus.out_valid), 32'h0);
        tick();
        chk("r2_grant_c2", 32'(bus.grant), 32'h4);
        chk("r2_out_c2", 32'(bus.out), 32'h2);
        chk("r2_valid_c2", 32'(bus.out_valid), 32'h1);
        tick();
        chk("r2_grant_c3", 32'(bus.grant), 32'h4);
        chk("r2_op_c3", 32'(bus.op), 32'h2);
        bus.req = 4'b0000;
        tick();
        chk("r2_rel_grant", 32'(bus.grant), 32'h0);
        chk("r2_rel_out", 32'(bus.out), 32'h2);
        chk("r2_rel_valid", 32'(bus.out_valid), 32'h1);
        tick();
        chk("r2_idle_valid", 32'(bus.out_valid), 32'h0);
        chk("r2_idle_out", 32'(bus.out), 32'h2);

        // ---- owner 1 drops while req[3] is high ----
        bus.req = 4'b0010;
        tick();
        chk("drop_grant1", 32'(bus.grant), 32'h2);
        bus.req = 4'b1010;
        tick();
        chk("drop_other_ignored", 32'(bus.grant), 32'h2);
        tick();
        chk("drop_still_owner1", 32'(bus.grant), 32'h2);
        bus.req = 4'b1000;
        tick();
        chk("drop_release", 32'(bus.grant), 32'h0);
        chk("drop_release_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("drop_grant3", 32'(bus.grant), 32'h8);
        chk("drop_op3", 32'(bus.op), 32'h3);
        bus.req = 4'b0000;
        tick();
        chk("drop3_release", 32'(bus.grant), 32'h0);

        // ---- out tracks in1 with one cycle latency ----
        bus.req = 4'b0010;
        tick();
        chk("trk_grant", 32'(bus.grant), 32'h2);
        for (int j = 0; j < 5; j++) begin
            v = 16'h5A00 + 16'(j * 17);
            bus.in1 = v;
            tick();
            chk("trk_out", 32'(bus.out), 32'(v));
            chk("trk_valid", 32'(bus.out_valid), 32'h1);
        end
        bus.req = 4'b0000;
        tick();
        chk("trk_release", 32'(bus.grant), 32'h0);

        // ---- reset in the 3rd cycle of owner 2 ----
        bus.req = 4'b0100;
        tick();
        chk("mr_grant_c1", 32'(bus.grant), 32'h4);
        tick();
        tick();
        chk("mr_grant_c3", 32'(bus.grant), 32'h4);
        reset = 1'b1;
        tick();
        chk("mr_grant", 32'(bus.grant), 32'h0);
        chk("mr_out", 32'(bus.out), 32'h0);
        chk("mr_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_op", 32'(bus.op), 32'h0);
        chk("mr_busy", 32'(bus.busy), 32'h0);
        reset   = 1'b0;
        bus.req = 4'b0110;
        tick();
        chk("mr_first_grant", 32'(bus.grant), 32'h2);
        chk("mr_first_op", 32'(bus.op), 32'h1);
        bus.req = 4'b0000;

        // ---- HOLD_MAX=1: one grant cycle per ownership ----
        bus1.req = 4'b1111;
        tick();
        chk("h1_grant0", 32'(bus1.grant), 32'h1);
        tick();
        chk("h1_gap0", 32'(bus1.grant), 32'h0);
        chk("h1_gap0_out", 32'(bus1.out), 32'hA0A0);
        chk("h1_gap0_valid", 32'(bus1.out_valid), 32'h1);
        tick();
        chk("h1_grant1", 32'(bus1.grant), 32'h2);
        tick();
        chk("h1_gap1", 32'(bus1.grant), 32'h0);
        chk("h1_gap1_out", 32'(bus1.out), 32'hA1A1);
        bus1.req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
